freq_counter: RTL and testbench

FREQ_COUNTER -- requirements
Module: freq_counter

---
 rtl/freq_counter.sv | 135 +++++++++++++
 tb/tb_freq_counter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/freq_counter.sv
// Gated frequency counter: counts synchronized rising edges of osc_in over a
// programmable window of clk cycles, single-shot or back-to-back.
`timescale 1ns/1ps
module freq_counter #(
    parameter int COUNT_W = 16,
    parameter int GATE_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               osc_in,
    input  logic               start,
    input  logic               continuous,
    input  logic [GATE_W-1:0]  gate_len,
    output logic [COUNT_W-1:0] count,
    output logic               count_valid,
    output logic               busy,
    output logic               overflow
);

    typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

    logic               s1_q, s2_q, s3_q;
    logic [1:0]         settle_q, settle_d;
    logic               armed_q, armed_d;
    state_t             state_q, state_d;
    logic [GATE_W-1:0]  gcnt_q, gcnt_d;
    logic [COUNT_W-1:0] acc_q, acc_d, acc_nxt;
    logic               flag_q, flag_d, flag_nxt;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               count_valid_q, count_valid_d;
    logic               busy_q, busy_d;
    logic               overflow_q, overflow_d;
    logic               edge_det;

    // Edges are only trusted once the synchronizer has seen osc_in low after
    // reset, so a level that is already high at release is never counted.
    assign edge_det = s2_q & ~s3_q & armed_q;

    always_comb begin
        settle_d      = {settle_q[0], 1'b1};
        armed_d       = armed_q | (settle_q[1] & ~s2_q);
        state_d       = state_q;
        gcnt_d        = gcnt_q;
        acc_d         = acc_q;
        flag_d        = flag_q;
        count_d       = count_q;
        count_valid_d = 1'b0;
        busy_d        = busy_q;
        overflow_d    = overflow_q;

        acc_nxt  = acc_q;
        flag_nxt = flag_q;
        if (edge_det) begin
            if (&acc_q) flag_nxt = 1'b1;
            else        acc_nxt  = acc_q + 1'b1;
        end

        case (state_q)
            IDLE, DONE: begin
                if ((state_q == IDLE && (start | continuous)) ||
                    (state_q == DONE && continuous)) begin
                    acc_d  = '0;
                    flag_d = 1'b0;
                    busy_d = 1'b1;
                    if (gate_len != '0) begin
                        state_d = GATE;
                        gcnt_d  = gate_len;
                    end else begin
                        state_d       = DONE;
                        count_d       = '0;
                        overflow_d    = 1'b0;
                        count_valid_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            GATE: begin
                acc_d  = acc_nxt;
                flag_d = flag_nxt;
                gcnt_d = gcnt_q - 1'b1;
                // Last gate cycle: publish the result including this cycle's edge.
                if (gcnt_q == GATE_W'(1)) begin
                    state_d       = DONE;
                    count_d       = acc_nxt;
                    overflow_d    = flag_nxt;
                    count_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            s3_q          <= 1'b0;
            settle_q      <= '0;
            armed_q       <= 1'b0;
            state_q       <= IDLE;
            gcnt_q        <= '0;
            acc_q         <= '0;
            flag_q        <= 1'b0;
            count_q       <= '0;
            count_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            s1_q          <= osc_in;
            s2_q          <= s1_q;
            s3_q          <= s2_q;
            settle_q      <= settle_d;
            armed_q       <= armed_d;
            state_q       <= state_d;
            gcnt_q        <= gcnt_d;
            acc_q         <= acc_d;
            flag_q        <= flag_d;
            count_q       <= count_d;
            count_valid_q <= count_valid_d;
            busy_q        <= busy_d;
            overflow_q    <= overflow_d;
        end
    end

    assign count       = count_q;
    assign count_valid = count_valid_q;
    assign busy        = busy_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_freq_counter.sv
// Scoreboarded bench for freq_counter: a default-width instance plus a
// COUNT_W=4 instance for saturation.
`timescale 1ns/1ps
module tb_freq_counter;

    typedef struct {
        int lo;
        int hi;
        bit ovf;
        int cyc;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        osc1 = 1'b0, start1 = 1'b0, cont1 = 1'b0;
    logic [15:0] gate1 = '0, count1;
    logic        vld1, busy1, ovf1;
    logic        osc2 = 1'b0, start2 = 1'b0, cont2 = 1'b0;
    logic [15:0] gate2 = '0;
    logic [3:0]  count2;
    logic        vld2, busy2, ovf2;

    real h1 = 5.0, h2 = 2.5;
    bit  run1 = 1'b1, lvl1 = 1'b0, run2 = 1'b1;
    int  cyc = 0;
    int  n_chk = 0, n_err = 0;
    exp_t q1[$], q2[$];
    exp_t e1, e2;

    freq_counter #(.COUNT_W(16), .GATE_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .osc_in(osc1), .start(start1), .continuous(cont1),
        .gate_len(gate1), .count(count1), .count_valid(vld1), .busy(busy1), .overflow(ovf1)
    );

    freq_counter #(.COUNT_W(4), .GATE_W(16)) u_dut2 (
        .clk(clk), .rst(rst), .osc_in(osc2), .start(start2), .continuous(cont2),
        .gate_len(gate2), .count(count2), .count_valid(vld2), .busy(busy2), .overflow(ovf2)
    );

    always #0.5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #0.23;
        forever begin
            #(h1);
            osc1 = run1 ? ~osc1 : lvl1;
        end
    end

    initial begin
        #0.37;
        forever begin
            #(h2);
            if (run2) osc2 = ~osc2;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && vld1) begin
            if (q1.size() == 0) chk("dut1_unexpected_valid", 1, 0);
            else begin
                e1 = q1.pop_front();
                chk($sformatf("dut1_count_%0d_in_%0d..%0d", count1, e1.lo, e1.hi),
                    (int'(count1) >= e1.lo && int'(count1) <= e1.hi), 1);
                chk("dut1_overflow", ovf1, e1.ovf);
                chk("dut1_valid_cycle", cyc, e1.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && vld2) begin
            if (q2.size() == 0) chk("dut2_unexpected_valid", 1, 0);
            else begin
                e2 = q2.pop_front();
                chk($sformatf("dut2_count_%0d_in_%0d..%0d", count2, e2.lo, e2.hi),
                    (int'(count2) >= e2.lo && int'(count2) <= e2.hi), 1);
                chk("dut2_overflow", ovf2, e2.ovf);
                chk("dut2_valid_cycle", cyc, e2.cyc);
            end
        end
    end

    // Called at a negedge: start is seen at the next posedge, result
    // appears n cycles later.
    task automatic go1(input int n, input int lo, input int hi, input bit ovf, input bit push);
        exp_t e;
        gate1 = 16'(n);
        start1 = 1'b1;
        e.lo = lo; e.hi = hi; e.ovf = ovf; e.cyc = cyc + 1 + n;
        if (push) q1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic go2(input int n, input int lo, input int hi, input bit ovf);
        exp_t e;
        gate2 = 16'(n);
        start2 = 1'b1;
        e.lo = lo; e.hi = hi; e.ovf = ovf; e.cyc = cyc + 1 + n;
        q2.push_back(e);
        @(negedge clk);
        start2 = 1'b0;
    endtask

    task automatic drain(input int budget, input string tag);
        int i;
        i = 0;
        while ((q1.size() != 0 || q2.size() != 0) && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_pending"}, q1.size() + q2.size(), 0);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int drop;
        repeat (4) @(negedge clk);
        chk("rst_count", count1, 0);
        chk("rst_valid", vld1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_overflow", ovf1, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // 100 MHz, 1000-cycle window; gate_len change and extra starts are ignored
        go1(1000, 99, 101, 0, 1);
        chk("busy_in_gate", busy1, 1);
        gate1 = 16'd7;
        start1 = 1'b1;
        repeat (3) @(negedge clk);
        start1 = 1'b0;
        repeat (400) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        drain(1200, "single");
        chk("count_hold", (count1 >= 16'd99 && count1 <= 16'd101), 1);

        // Zero-length gate
        go1(0, 0, 0, 0, 1);
        chk("gate0_busy", busy1, 1);
        drain(20, "gate0");

        // Continuous at 250 MHz, released mid third window
        h1 = 2.0;
        repeat (10) @(negedge clk);
        begin
            exp_t e;
            int k;
            k = cyc;
            gate1 = 16'd400;
            cont1 = 1'b1;
            for (int w = 0; w < 3; w++) begin
                e.lo = 99; e.hi = 101; e.ovf = 1'b0; e.cyc = k + 401 * (w + 1);
                q1.push_back(e);
            end
            drop = 0;
            for (int i = 1; i <= 1203; i++) begin
                @(negedge clk);
                if (i == 900) cont1 = 1'b0;
                if (!busy1) drop++;
            end
            chk("cont_busy_drops", drop, 0);
        end
        drain(50, "cont");
        chk("cont_idle_busy", busy1, 0);

        // Saturation on the 4-bit instance, then a slow window
        go2(200, 15, 15, 1);
        drain(300, "sat");
        h2 = 50.0;
        repeat (120) @(negedge clk);
        go2(100, 0, 2, 0);
        drain(200, "slow");

        // Reset mid-window aborts it
        h1 = 5.0;
        repeat (10) @(negedge clk);
        go1(1000, 0, 0, 0, 0);
        repeat (499) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_count", count1, 0);
        chk("midrst_busy", busy1, 0);
        chk("midrst_overflow", ovf1, 0);
        chk("midrst_count2", count2, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (700) @(negedge clk);
        chk("midrst_no_start_busy", busy1, 0);
        go1(1000, 99, 101, 0, 1);
        drain(1200, "post_rst");

        // Constant low osc
        run1 = 1'b0;
        lvl1 = 1'b0;
        repeat (20) @(negedge clk);
        go1(300, 0, 0, 0, 1);
        drain(400, "const_low");

        // High level across reset release must not count
        lvl1 = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        go1(300, 0, 0, 0, 1);
        drain(400, "const_high");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
